// File: rtl/layer_object_compositor_if.sv
// rtl/layer_object_compositor_if.sv - slot binding bus between compositor and alien renderers
// Ports (signals):
//   slot_idx       object index bound to each slot (compositor -> renderer)
//   slot_en        slot holds a valid binding (compositor -> renderer)
//   slot_pix_valid renderer pixel valid per slot (renderer -> compositor)
//   slot_palette   palette bit per slot (renderer -> compositor)
//   slot_deriv     deriv_select per slot, 2 bits each (renderer -> compositor)
interface layer_object_compositor_if #(
    parameter int SLOTS = 4,
    parameter int IDX_W = 4
);
    logic [SLOTS*IDX_W-1:0] slot_idx;
    logic [SLOTS-1:0]       slot_en;
    logic [SLOTS-1:0]       slot_pix_valid;
    logic [SLOTS-1:0]       slot_palette;
    logic [SLOTS*2-1:0]     slot_deriv;

    modport master (
        output slot_idx,
        output slot_en,
        input  slot_pix_valid,
        input  slot_palette,
        input  slot_deriv
    );

    modport slave (
        input  slot_idx,
        input  slot_en,
        output slot_pix_valid,
        output slot_palette,
        output slot_deriv
    );
endinterface

// File: rtl/layer_object_compositor.sv
// rtl/layer_object_compositor.sv - distance-sorted render slot allocation and per-pixel layer colour
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   h_cnt, v_cnt        current pixel position (frame_end detection)
//   in_frame            per-object visibility in this quadrant
//   obj_dist/type/frame per-object distance (4b), alien type (2b), animation frame (2b)
//   slot_bus            slot bindings out, renderer pixel data in
//   scan_busy           slot scan (SCAN or COMMIT) in progress
//   overflow            last committed frame had more visible objects than slots
//   layer_valid         registered: some slot owns the current pixel
//   pixel_out           registered RGB444 colour
module layer_object_compositor #(
    parameter int OBJ_LIMIT = 16,
    parameter int SLOTS     = 4,
    parameter int IDX_W     = 4,
    parameter int VGA_XRES  = 640,
    parameter int VGA_YRES  = 480
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [9:0]             h_cnt,
    input  logic [9:0]             v_cnt,
    input  logic [OBJ_LIMIT-1:0]   in_frame,
    input  logic [OBJ_LIMIT*4-1:0] obj_dist,
    input  logic [OBJ_LIMIT*2-1:0] obj_type,
    input  logic [OBJ_LIMIT*2-1:0] obj_frame,
    layer_object_compositor_if.master slot_bus,
    output logic                   scan_busy,
    output logic                   overflow,
    output logic                   layer_valid,
    output logic [11:0]            pixel_out
);
    localparam int CNT_W = $clog2(SLOTS + 1);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t state, state_n;
    logic   start_scan;
    logic   do_commit;
    logic   frame_end;

    // Snapshot of the object table taken at frame_end; the scan only reads this.
    logic [OBJ_LIMIT-1:0]   snap_in_frame;
    logic [OBJ_LIMIT*4-1:0] snap_dist;
    logic [OBJ_LIMIT*2-1:0] snap_type;
    logic [IDX_W-1:0]       scan_i;

    // Shadow list, sorted ascending by distance, entries [0, sh_cnt) valid.
    logic [IDX_W-1:0] sh_idx   [SLOTS];
    logic [3:0]       sh_dist  [SLOTS];
    logic [CNT_W-1:0] sh_cnt;
    logic             sh_ovf;

    logic [IDX_W-1:0] sh_idx_n  [SLOTS];
    logic [3:0]       sh_dist_n [SLOTS];
    logic [CNT_W-1:0] sh_cnt_n;
    logic             sh_full;
    logic [3:0]       cur_d;
    int               ins_pos;

    // Active (committed) bindings. The type is latched at commit so a restarted
    // scan's fresh snapshot cannot change how the current bindings render.
    logic [IDX_W-1:0] act_idx  [SLOTS];
    logic [1:0]       act_type [SLOTS];
    logic [SLOTS-1:0] act_en;

    assign frame_end = (h_cnt == 10'(VGA_XRES - 1)) && (v_cnt == 10'(VGA_YRES - 1));
    assign scan_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        start_scan = 1'b0;
        do_commit  = 1'b0;
        case (state)
            IDLE: begin
                if (frame_end) begin
                    start_scan = 1'b1;
                    state_n    = SCAN;
                end
            end
            SCAN: begin
                if (frame_end)                             start_scan = 1'b1;
                else if (scan_i == IDX_W'(OBJ_LIMIT - 1))  state_n    = COMMIT;
            end
            COMMIT: begin
                // A frame_end here restarts without touching the active slots.
                if (frame_end) begin
                    start_scan = 1'b1;
                    state_n    = SCAN;
                end else begin
                    do_commit  = 1'b1;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Sorted insert: the new object goes after every entry whose distance is
    // <= its own, so equal distances keep the earlier (lower) index ahead.
    // ins_pos == SLOTS means the list is full and the new object sorts last.
    always_comb begin
        cur_d   = snap_dist[{scan_i, 2'b00} +: 4];
        sh_full = (int'(sh_cnt) == SLOTS);
        ins_pos = 0;
        for (int k = 0; k < SLOTS; k++) begin
            if (k < int'(sh_cnt) && sh_dist[k] <= cur_d) ins_pos = k + 1;
        end
        for (int k = 0; k < SLOTS; k++) begin
            if (k < ins_pos) begin
                sh_idx_n[k]  = sh_idx[k];
                sh_dist_n[k] = sh_dist[k];
            end else if (k == ins_pos) begin
                sh_idx_n[k]  = scan_i;
                sh_dist_n[k] = cur_d;
            end else begin
                sh_idx_n[k]  = sh_idx[(k == 0) ? 0 : k - 1];
                sh_dist_n[k] = sh_dist[(k == 0) ? 0 : k - 1];
            end
        end
        sh_cnt_n = sh_full ? sh_cnt : sh_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_in_frame <= '0;
            snap_dist     <= '0;
            snap_type     <= '0;
            scan_i        <= '0;
            sh_cnt        <= '0;
            sh_ovf        <= 1'b0;
            act_en        <= '0;
            overflow      <= 1'b0;
            for (int k = 0; k < SLOTS; k++) begin
                sh_idx[k]   <= '0;
                sh_dist[k]  <= '0;
                act_idx[k]  <= '0;
                act_type[k] <= '0;
            end
        end else begin
            if (start_scan) begin
                snap_in_frame <= in_frame;
                snap_dist     <= obj_dist;
                snap_type     <= obj_type;
                scan_i        <= '0;
                sh_cnt        <= '0;
                sh_ovf        <= 1'b0;
                for (int k = 0; k < SLOTS; k++) begin
                    sh_idx[k]  <= '0;
                    sh_dist[k] <= '0;
                end
            end else if (state == SCAN) begin
                scan_i <= scan_i + IDX_W'(1);
                if (snap_in_frame[scan_i]) begin
                    sh_cnt <= sh_cnt_n;
                    if (sh_full) sh_ovf <= 1'b1;
                    for (int k = 0; k < SLOTS; k++) begin
                        sh_idx[k]  <= sh_idx_n[k];
                        sh_dist[k] <= sh_dist_n[k];
                    end
                end
            end
            if (do_commit) begin
                overflow <= sh_ovf;
                for (int k = 0; k < SLOTS; k++) begin
                    act_en[k]   <= (k < int'(sh_cnt));
                    act_idx[k]  <= sh_idx[k];
                    act_type[k] <= snap_type[{sh_idx[k], 1'b0} +: 2];
                end
            end
        end
    end

    for (genvar s = 0; s < SLOTS; s++) begin : g_pack
        assign slot_bus.slot_idx[s*IDX_W +: IDX_W] = act_idx[s];
    end
    assign slot_bus.slot_en = act_en;

    // Pixel ownership: slot 0 holds the nearest object, so the lowest hit wins.
    logic [SLOTS-1:0] hit;
    logic             any_hit;
    logic [IDX_W-1:0] win_idx;
    logic [1:0]       win_type;
    logic [3:0]       win_d;
    logic [1:0]       win_f;
    logic [3:0]       dim;
    logic [3:0]       bright;
    logic [11:0]      colour;

    always_comb begin
        any_hit  = 1'b0;
        win_idx  = '0;
        win_type = '0;
        for (int s = 0; s < SLOTS; s++) begin
            hit[s] = act_en[s] && slot_bus.slot_pix_valid[s] &&
                     ((act_type[s] > 2'd1 && !slot_bus.slot_palette[s] &&
                       slot_bus.slot_deriv[2*s +: 2] <= 2'd1) ||
                      (act_type[s] <= 2'd1 && slot_bus.slot_palette[s]));
        end
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (hit[s]) begin
                any_hit  = 1'b1;
                win_idx  = act_idx[s];
                win_type = act_type[s];
            end
        end
        // Distance and animation frame are live so dimming tracks motion.
        win_d  = obj_dist[{win_idx, 2'b00} +: 4];
        win_f  = obj_frame[{win_idx, 1'b0} +: 2];
        dim    = 4'd4 - (win_d >> 3);
        bright = 4'hF - win_d;
        if (win_f > 2'd1) begin
            colour = 12'h222;
        end else begin
            case (win_type)
                2'd0:    colour = {dim, dim, bright};
                2'd1:    colour = {dim, bright, dim};
                2'd2:    colour = {bright, dim, dim};
                default: colour = {bright, dim, bright};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            layer_valid <= 1'b0;
            pixel_out   <= '0;
        end else begin
            layer_valid <= any_hit;
            pixel_out   <= any_hit ? colour : 12'h000;
        end
    end
endmodule

// File: tb/tb_layer_object_compositor.sv
// tb/tb_layer_object_compositor.sv - directed self-checking bench for layer_object_compositor
module tb_layer_object_compositor;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  h_cnt, v_cnt;
    logic [15:0] in_frame;
    logic [63:0] obj_dist;
    logic [31:0] obj_type;
    logic [31:0] obj_frame;
    logic        scan_busy, overflow, layer_valid;
    logic [11:0] pixel_out;

    int n_tests = 0;
    int n_fail  = 0;

    layer_object_compositor_if #(.SLOTS(4), .IDX_W(4)) bus ();

    layer_object_compositor dut (
        .clk         (clk),
        .rst         (rst),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .in_frame    (in_frame),
        .obj_dist    (obj_dist),
        .obj_type    (obj_type),
        .obj_frame   (obj_frame),
        .slot_bus    (bus),
        .scan_busy   (scan_busy),
        .overflow    (overflow),
        .layer_valid (layer_valid),
        .pixel_out   (pixel_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_objs();
        in_frame  = '0;
        obj_dist  = '0;
        obj_type  = '0;
        obj_frame = '0;
    endtask

    task automatic set_obj(input int i, input logic [3:0] d, input logic [1:0] t, input logic [1:0] f);
        in_frame[i]       = 1'b1;
        obj_dist[4*i +: 4] = d;
        obj_type[2*i +: 2] = t;
        obj_frame[2*i +: 2] = f;
    endtask

    // Called just after a rising edge; the next edge samples frame_end.
    task automatic pulse_frame_end();
        h_cnt = 10'd639;
        v_cnt = 10'd479;
        @(posedge clk); #1;
        h_cnt = 10'd0;
        v_cnt = 10'd0;
    endtask

    task automatic run_scan();
        pulse_frame_end();
        repeat (17) @(posedge clk);
        #1;
    endtask

    task automatic check_slots(input string tag, input logic [15:0] idx, input logic [3:0] en, input logic ovf);
        check({tag, "_idx"}, 32'(bus.slot_idx), 32'(idx));
        check({tag, "_en"},  32'(bus.slot_en),  32'(en));
        check({tag, "_ovf"}, 32'(overflow),     32'(ovf));
    endtask

    // Drive renderer inputs now, then sample the registered pixel one edge later.
    task automatic pix(input string tag, input logic [3:0] pv, input logic [3:0] pal,
                       input logic [7:0] der, input logic vld, input logic [11:0] rgb);
        bus.slot_pix_valid = pv;
        bus.slot_palette   = pal;
        bus.slot_deriv     = der;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid"}, 32'(layer_valid), 32'(vld));
        check({tag, "_rgb"},   32'(pixel_out),   32'(rgb));
    endtask

    initial begin
        // Reset with random inputs
        rst = 1'b1;
        h_cnt = 10'($urandom);
        v_cnt = 10'($urandom);
        in_frame  = 16'($urandom);
        obj_dist  = {$urandom, $urandom};
        obj_type  = $urandom;
        obj_frame = $urandom;
        bus.slot_pix_valid = 4'($urandom);
        bus.slot_palette   = 4'($urandom);
        bus.slot_deriv     = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check("rst_slot_en", 32'(bus.slot_en), 32'h0);
        check("rst_layer_valid", 32'(layer_valid), 32'h0);
        check("rst_pixel", 32'(pixel_out), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_busy", 32'(scan_busy), 32'h0);
        rst = 1'b0;
        h_cnt = 10'd0;
        v_cnt = 10'd0;
        bus.slot_pix_valid = '0;
        bus.slot_palette   = '0;
        bus.slot_deriv     = '0;
        clear_objs();
        @(posedge clk); #1;

        // Sort with a distance tie (2 and 9 both at 7) and latency check
        set_obj(2, 4'd7, 2'd0, 2'd0);
        set_obj(5, 4'd3, 2'd0, 2'd0);
        set_obj(9, 4'd7, 2'd0, 2'd0);
        pulse_frame_end();
        check("sort_busy0", 32'(scan_busy), 32'h1);
        repeat (16) @(posedge clk);
        #1;
        check("sort_pre_en", 32'(bus.slot_en), 32'h0);
        check("sort_pre_busy", 32'(scan_busy), 32'h1);
        @(posedge clk); #1;
        check_slots("sort", 16'h0925, 4'b0111, 1'b0);
        check("sort_busy_done", 32'(scan_busy), 32'h0);

        // Overflow: six objects, four slots
        clear_objs();
        set_obj(0, 4'd9, 2'd0, 2'd0);
        set_obj(1, 4'd1, 2'd0, 2'd0);
        set_obj(2, 4'd8, 2'd0, 2'd0);
        set_obj(3, 4'd2, 2'd0, 2'd0);
        set_obj(4, 4'd7, 2'd0, 2'd0);
        set_obj(5, 4'd3, 2'd0, 2'd0);
        run_scan();
        check_slots("ovf", 16'h4531, 4'b1111, 1'b1);

        // Two objects clears overflow; also sets up the pixel test
        clear_objs();
        set_obj(3, 4'd2, 2'd0, 2'd0);
        set_obj(7, 4'd5, 2'd1, 2'd0);
        run_scan();
        check_slots("two", 16'h0073, 4'b0011, 1'b0);

        // Pixel priority: both slots hit, slot0 (type0, d=2) wins
        pix("pix_both", 4'b0011, 4'b0011, 8'h00, 1'b1, 12'h44D);

        // Slot0 becomes type2
        clear_objs();
        set_obj(3, 4'd2, 2'd2, 2'd0);
        set_obj(7, 4'd5, 2'd1, 2'd0);
        run_scan();
        check_slots("t2", 16'h0073, 4'b0011, 1'b0);
        pix("pix_deriv2", 4'b0011, 4'b0010, 8'h02, 1'b1, 12'h4A4);
        pix("pix_t2_hit", 4'b0011, 4'b0010, 8'h01, 1'b1, 12'hD44);
        obj_frame[2*3 +: 2] = 2'd2;
        pix("pix_dying", 4'b0011, 4'b0010, 8'h01, 1'b1, 12'h222);
        pix("pix_none", 4'b0000, 4'b0010, 8'h01, 1'b0, 12'h000);
        obj_dist[4*7 +: 4] = 4'd9;
        pix("pix_live_d9", 4'b0010, 4'b0010, 8'h00, 1'b1, 12'h363);
        pix("pix_en_gate", 4'b1100, 4'b1100, 8'h00, 1'b0, 12'h000);
        bus.slot_pix_valid = '0;
        @(posedge clk); #1;

        // Restart: second frame_end at scan index 5
        clear_objs();
        set_obj(0, 4'd4, 2'd0, 2'd0);
        set_obj(1, 4'd4, 2'd0, 2'd0);
        pulse_frame_end();
        repeat (5) @(posedge clk);
        #1;
        clear_objs();
        set_obj(12, 4'd3, 2'd0, 2'd0);
        set_obj(13, 4'd1, 2'd0, 2'd0);
        set_obj(14, 4'd2, 2'd0, 2'd0);
        pulse_frame_end();
        repeat (11) @(posedge clk);
        #1;
        check_slots("rs_first_due", 16'h0073, 4'b0011, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("rs_pre_idx", 32'(bus.slot_idx), 32'h0073);
        check("rs_pre_busy", 32'(scan_busy), 32'h1);
        @(posedge clk); #1;
        check_slots("rs_new", 16'h0CED, 4'b0111, 1'b0);

        // Reset mid-scan at index 8
        clear_objs();
        set_obj(15, 4'd0, 2'd0, 2'd0);
        set_obj(0,  4'd15, 2'd0, 2'd0);
        pulse_frame_end();
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_slots("mid_rst", 16'h0000, 4'b0000, 1'b0);
        check("mid_rst_busy", 32'(scan_busy), 32'h0);
        repeat (20) @(posedge clk);
        #1;
        check("mid_rst_quiet_en", 32'(bus.slot_en), 32'h0);
        run_scan();
        check_slots("after_rst", 16'h000F, 4'b0011, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/layer_object_compositor.md
Name: layer_object_compositor

Overview:
- Parametrised successor to the per-quadrant object layer. Each frame it picks which in-frame aliens get one of SLOTS render slots, ordered nearest first. Per pixel it resolves which slot owns the pixel and produces the layer colour.
- Slot selection is a sequential scan during vertical blanking, replacing the combinational first-N search. Priority is by distance, not by object index. Slot loss is flagged.
- Sits between the alien renderers / alien pixel readers and the layer mixer.

Parameters:
- OBJ_LIMIT, 16, number of object records scanned per frame.
- SLOTS, 4, number of render slots (1..OBJ_LIMIT).
- IDX_W, 4, object index width (clog2(OBJ_LIMIT)).
- VGA_XRES, 640, horizontal resolution.
- VGA_YRES, 480, vertical resolution.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- h_cnt  in  10  current pixel column.
- v_cnt  in  10  current pixel row.
- in_frame  in  OBJ_LIMIT  bit i set when object i is visible in this quadrant.
- obj_dist  in  OBJ_LIMIT*4  distance _r per object; object i at [4i+3:4i].
- obj_type  in  OBJ_LIMIT*2  alien type per object.
- obj_frame  in  OBJ_LIMIT*2  animation frame per object (values 2 and 3 mean dying/flash).
- slot_pix_valid  in  SLOTS  renderer valid for the object currently bound to slot s.
- slot_palette  in  SLOTS  palette bit read from block memory for slot s.
- slot_deriv  in  SLOTS*2  deriv_select for slot s.
- slot_idx  out  SLOTS*IDX_W  object index bound to slot s.
- slot_en  out  SLOTS  slot s holds a valid binding.
- scan_busy  out  1  scan in progress.
- overflow  out  1  more in-frame objects than SLOTS in the last committed frame.
- layer_valid  out  1  registered: some slot owns the current pixel.
- pixel_out  out  12  registered RGB444 colour.

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE, shadow list cleared. Reset mid-scan aborts the scan and clears the active slots.
- frame_end = (h_cnt==VGA_XRES-1 && v_cnt==VGA_YRES-1).
- FSM states: IDLE, SCAN, COMMIT.
- IDLE: on frame_end, snapshot in_frame, obj_dist and obj_type; clear the shadow list and the shadow overflow bit; i=0; go to SCAN.
- SCAN: one object per cycle, index i taken from the snapshot.
  - If in_frame[i], insert i into the shadow list, kept sorted ascending by distance; ties go to the lower index, so the existing entry stays ahead of the new one.
  - If the list is full and the new entry sorts before the last entry: evict the last entry and set shadow overflow.
  - If the list is full and the new entry does not sort earlier: drop it and set shadow overflow.
  - After i=OBJ_LIMIT-1, go to COMMIT.
- COMMIT (one cycle): copy shadow indices to slot_idx, set slot_en to the occupied entries (contiguous from slot 0), copy shadow overflow to overflow; go to IDLE.
- Latency: the active slots change at the (OBJ_LIMIT+1)th edge after the edge that samples frame_end. scan_busy is high in SCAN and COMMIT. The active slots are stable for the whole visible frame.
- frame_end while in SCAN or COMMIT: restart the scan with a fresh snapshot at i=0; the active slots are not changed.
- Pixel hit for slot s:
  - slot_en[s] && slot_pix_valid[s], and
  - either (type>1 && !palette && deriv<=1) or (type<=1 && palette).
  - type is the snapshot obj_type of the object in slot_idx[s].
- The lowest-numbered hitting slot wins, which is the nearest object.
- Colour, with d = live obj_dist and f = live obj_frame of the winning slot's object:
  - If f<=1: type0 = {4-(d>>3), 4-(d>>3), F-d}; type1 = {4-(d>>3), F-d, 4-(d>>3)}; type2 = {F-d, 4-(d>>3), 4-(d>>3)}; type3 = {F-d, 4-(d>>3), F-d}.
  - Otherwise 12'h222.
  - All nibble arithmetic is modulo 16.
- No hit: layer_valid=0, pixel_out=0.
- The pixel path is registered: one cycle from the slot_* inputs and h/v to layer_valid and pixel_out.

Test Plan:
- Reset: assert rst for 3 cycles with random inputs -> slot_en=0, layer_valid=0, pixel_out=0, overflow=0, scan_busy=0.
- Sort: in_frame bits 2,5,9 set, distances 7,3,7, pulse frame_end -> after OBJ_LIMIT+1 edges: slot0=5, slot1=2, slot2=9, slot_en=4'b0111, overflow=0.
- Overflow: objects 0..5 in frame with distances 9,1,8,2,7,3 -> slots hold indices 1,3,5,4; overflow=1; next frame with 2 objects -> overflow=0.
- Pixel priority: slots 0 and 1 both hit, slot0 object type0, d=2, f=0 -> next cycle layer_valid=1, pixel_out=12'h44D. Slot0 type2 with palette=0, deriv=2 -> slot1 wins. f=2 on the winner -> 12'h222.
- Restart: pulse frame_end again at scan index 5 -> active slots unchanged until OBJ_LIMIT+1 edges after the second pulse, and they then reflect the second snapshot.
- Reset mid-scan: rst at scan index 8 -> slot_en=0, FSM IDLE; next frame_end scans normally.
